// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, lane entry type and modular index helper
package cdb_arbiter_pkg;
    localparam int CDB_REQS   = 6;
    localparam int CDB_LANES  = 2;
    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;
    typedef logic [CDB_DATA_W-1:0] rv32i_word;
    typedef struct packed {
        logic                 valid;
        logic [CDB_TAG_W-1:0] tag;
        rv32i_word            value;
    } cdb_entry_t;
    typedef cdb_entry_t [CDB_LANES-1:0] cdb_t;
    // a and b are both below n, so a single conditional subtract is an exact mod
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return s >= n ? s - n : s;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_multi_select.sv
// cdb_arbiter_rr_multi_select: picks up to NUM_LANES requesters in circular order from rr_ptr
module cdb_arbiter_rr_multi_select
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = CDB_REQS,
    parameter int NUM_LANES = CDB_LANES,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                req,
    input  logic [IDX_W-1:0]                  rr_ptr,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [NUM_LANES-1:0]              lane_vld,
    output logic [NUM_LANES-1:0][IDX_W-1:0]   lane_idx,
    output logic [IDX_W-1:0]                  next_ptr
);
    // Walk requesters from rr_ptr; the n-th hit takes lane n, pointer lands after the last hit
    always_comb begin
        logic [IDX_W-1:0] idx;
        int cnt;
        gnt      = '0;
        lane_vld = '0;
        lane_idx = '0;
        next_ptr = rr_ptr;
        cnt      = 0;
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = IDX_W'(wrap_add(int'(rr_ptr), o, NUM_REQ));
            if (req[idx] && cnt < NUM_LANES) begin
                gnt[idx] = 1'b1;
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (k == cnt) begin
                        lane_vld[k] = 1'b1;
                        lane_idx[k] = idx;
                    end
                end
                next_ptr = IDX_W'(wrap_add(int'(idx), 1, NUM_REQ));
                cnt++;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of result producers onto registered CDB broadcast lanes
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = CDB_REQS,
    parameter int NUM_LANES = CDB_LANES,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic [NUM_LANES-1:0]        cdb_valid,
    output logic [NUM_LANES*TAG_W-1:0]  cdb_tag,
    output logic [NUM_LANES*DATA_W-1:0] cdb_value,
    output logic [NUM_LANES*IDX_W-1:0]  cdb_src
);
    logic                             en;
    logic [IDX_W-1:0]                 rr_ptr;
    logic [IDX_W-1:0]                 next_ptr;
    logic [NUM_LANES-1:0]             lane_vld;
    logic [NUM_LANES-1:0][IDX_W-1:0]  lane_idx;
    logic [NUM_LANES-1:0][TAG_W-1:0]  lane_tag;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_value;

    assign en = rst & ~flush;

    cdb_arbiter_rr_multi_select #(
        .NUM_REQ   (NUM_REQ),
        .NUM_LANES (NUM_LANES)
    ) u_sel (
        .req      (req_valid & {NUM_REQ{en}}),
        .rr_ptr   (rr_ptr),
        .gnt      (req_gnt),
        .lane_vld (lane_vld),
        .lane_idx (lane_idx),
        .next_ptr (next_ptr)
    );

    // Steer each winner's tag and value onto its lane
    always_comb begin
        lane_tag   = '0;
        lane_value = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lane_idx[k] == IDX_W'(i)) begin
                    lane_tag[k]   = req_tag[i*TAG_W +: TAG_W];
                    lane_value[k] = req_value[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Register winners for one-cycle broadcast; idle lanes keep stale tag/value/src
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_src   <= '0;
        end else begin
            rr_ptr    <= flush ? '0 : next_ptr;
            cdb_valid <= lane_vld;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_vld[k]) begin
                    cdb_tag[k*TAG_W +: TAG_W]    <= lane_tag[k];
                    cdb_value[k*DATA_W +: DATA_W] <= lane_value[k];
                    cdb_src[k*IDX_W +: IDX_W]    <= lane_idx[k];
                end
            end
        end
    end
endmodule
